// File: rtl/buffer_bb_to_stage_p.sv
// Moves one frame of N items from a buffer_BB into a stage memory, packing
// P consecutive items into each write, with optional bit-reversed addressing.
module buffer_bb_to_stage_p #(
  parameter int unsigned N      = 8,
  parameter int unsigned LOG_N  = 3,
  parameter int unsigned P      = 2,
  parameter int unsigned LOG_P  = 1,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MWIDTH = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    bitrev_i,
  input  logic                    read_full_i,
  input  logic [WIDTH+MWIDTH-1:0] read_data_i,
  output logic                    read_delete_o,
  output logic [P*LOG_N-1:0]      out_addr_o,
  output logic [P*WIDTH-1:0]      out_data_o,
  output logic                    out_nd_o,
  output logic                    out_mnd_o,
  output logic [MWIDTH-1:0]       out_m_o,
  output logic                    done_o,
  output logic                    active_o,
  output logic                    error_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                      state_q, state_d;
  logic [LOG_N-1:0]            idx_q, idx_d;
  logic                        mode_q, mode_d;
  logic [P-1:0][WIDTH-1:0]     slots_q, slots_d;
  logic [P*WIDTH-1:0]          data_q, data_d;
  logic [P*LOG_N-1:0]          addr_q, addr_d;
  logic [MWIDTH-1:0]           m_q, m_d;
  logic                        nd_q, nd_d;
  logic                        mnd_q, mnd_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;

  logic                        consume;
  logic [WIDTH-1:0]            sample;
  logic [LOG_N-1:0]            base;

  // Address of item i within the frame, natural or bit-reversed order.
  function automatic logic [LOG_N-1:0] map_addr(input logic [LOG_N-1:0] i, input logic rev);
    logic [LOG_N-1:0] r;
    for (int unsigned b = 0; b < LOG_N; b++) begin
      r[b] = i[LOG_N-1-b];
    end
    return rev ? r : i;
  endfunction

  // An item is taken only while running and never in a start or reset cycle.
  assign consume       = (state_q == RUN) & read_full_i & ~start_i & ~rst_i;
  assign read_delete_o = consume;
  assign active_o      = (state_q == RUN) | start_i;
  assign sample        = read_data_i[WIDTH+MWIDTH-1:MWIDTH];

  // Next-state: frame control, group packing and strobe generation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    slots_d = slots_q;
    data_d  = data_q;
    addr_d  = addr_q;
    m_d     = m_q;
    nd_d    = 1'b0;
    mnd_d   = 1'b0;
    done_d  = 1'b0;
    error_d = error_q;
    base    = idx_q - LOG_N'(P - 1);

    if (start_i) begin
      if (state_q == IDLE) begin
        state_d = RUN;
        idx_d   = '0;
        mode_d  = bitrev_i;
      end else begin
        error_d = 1'b1;
      end
    end

    if (consume) begin
      slots_d[idx_q[LOG_P-1:0]] = sample;
      mnd_d = 1'b1;
      m_d   = read_data_i[MWIDTH-1:0];
      idx_d = idx_q + LOG_N'(1);
      if (idx_q[LOG_P-1:0] == LOG_P'(P - 1)) begin
        nd_d = 1'b1;
        for (int unsigned k = 0; k < P; k++) begin
          data_d[k*WIDTH +: WIDTH] = (k == P - 1) ? sample : slots_q[k];
          addr_d[k*LOG_N +: LOG_N] = map_addr(base + LOG_N'(k), mode_q);
        end
      end
      if (idx_q == LOG_N'(N - 1)) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // State register with synchronous reset; a partial group is simply dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      slots_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      m_q     <= '0;
      nd_q    <= 1'b0;
      mnd_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      slots_q <= slots_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      m_q     <= m_d;
      nd_q    <= nd_d;
      mnd_q   <= mnd_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign out_addr_o = addr_q;
  assign out_data_o = data_q;
  assign out_nd_o   = nd_q;
  assign out_mnd_o  = mnd_q;
  assign out_m_o    = m_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_buffer_bb_to_stage_p.sv
// Drives a P=2 and a P=4 instance with identical stimulus and compares both
// against a frame-level reference model.
module tb_buffer_bb_to_stage_p;

  logic        clk;
  logic        rst_r, start_r, bitrev_r, rf_r;
  logic [32:0] rd_r;

  logic        del0, del1, nd0, nd1, mnd0, mnd1, m0, m1;
  logic        done0, done1, act0, act1, err0, err1;
  logic [5:0]  addr0;
  logic [11:0] addr1;
  logic [63:0] data0;
  logic [127:0] data1;

  int n_chk = 0;
  int n_err = 0;

  // reference model state, index 0 -> P=2, index 1 -> P=4
  int           m_act[2], m_cnt[2], m_mode[2], m_err[2];
  logic [31:0]  m_items[2][8];
  logic         e_nd[2], e_mnd[2], e_m[2], e_done[2];
  logic [127:0] e_data[2];
  logic [11:0]  e_addr[2];

  logic         cap_en, cap_done;
  logic [11:0]  cap_addr;
  int           tog;

  buffer_bb_to_stage_p #(.N(8), .LOG_N(3), .P(2), .LOG_P(1), .WIDTH(32), .MWIDTH(1)) u_p2 (
    .clk_i(clk), .rst_i(rst_r), .start_i(start_r), .bitrev_i(bitrev_r),
    .read_full_i(rf_r), .read_data_i(rd_r), .read_delete_o(del0),
    .out_addr_o(addr0), .out_data_o(data0), .out_nd_o(nd0), .out_mnd_o(mnd0),
    .out_m_o(m0), .done_o(done0), .active_o(act0), .error_o(err0));

  buffer_bb_to_stage_p #(.N(8), .LOG_N(3), .P(4), .LOG_P(2), .WIDTH(32), .MWIDTH(1)) u_p4 (
    .clk_i(clk), .rst_i(rst_r), .start_i(start_r), .bitrev_i(bitrev_r),
    .read_full_i(rf_r), .read_data_i(rd_r), .read_delete_o(del1),
    .out_addr_o(addr1), .out_data_o(data1), .out_nd_o(nd1), .out_mnd_o(mnd1),
    .out_m_o(m1), .done_o(done1), .active_o(act1), .error_o(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  // One clock of the frame-level reference for the instance with group size p.
  task automatic model_step(input int j, input int p);
    int a;
    if (rst_r) begin
      m_act[j] = 0; m_cnt[j] = 0; m_mode[j] = 0; m_err[j] = 0;
      e_nd[j] = 0; e_mnd[j] = 0; e_m[j] = 0; e_done[j] = 0;
      e_data[j] = '0; e_addr[j] = '0;
      return;
    end
    e_nd[j] = 0; e_mnd[j] = 0; e_done[j] = 0;
    if (m_act[j] != 0 && rf_r && !start_r) begin
      m_items[j][m_cnt[j]] = rd_r[32:1];
      e_mnd[j] = 1;
      e_m[j]   = rd_r[0];
      if (m_cnt[j] % p == p - 1) begin
        e_nd[j] = 1;
        e_data[j] = '0;
        e_addr[j] = '0;
        for (int k = 0; k < p; k++) begin
          a = m_cnt[j] - p + 1 + k;
          e_data[j] = e_data[j] | (128'(m_items[j][a]) << (32 * k));
          if (m_mode[j] != 0) a = rev3(a);
          e_addr[j] = e_addr[j] | (12'(a) << (3 * k));
        end
      end
      if (m_cnt[j] == 7) begin
        e_done[j] = 1;
        m_act[j]  = 0;
      end
      m_cnt[j] = (m_cnt[j] + 1) % 8;
    end else if (start_r) begin
      if (m_act[j] != 0) m_err[j] = 1;
      else begin
        m_act[j] = 1; m_cnt[j] = 0; m_mode[j] = bitrev_r ? 1 : 0;
      end
    end
  endtask

  task automatic check_regs();
    chk("p2_nd",   128'(nd0),   128'(e_nd[0]));
    chk("p2_mnd",  128'(mnd0),  128'(e_mnd[0]));
    chk("p2_m",    128'(m0),    128'(e_m[0]));
    chk("p2_done", 128'(done0), 128'(e_done[0]));
    chk("p2_err",  128'(err0),  128'(m_err[0] != 0));
    chk("p2_addr", 128'(addr0), 128'(e_addr[0][5:0]));
    chk("p2_data", 128'(data0), 128'(e_data[0][63:0]));
    chk("p4_nd",   128'(nd1),   128'(e_nd[1]));
    chk("p4_mnd",  128'(mnd1),  128'(e_mnd[1]));
    chk("p4_m",    128'(m1),    128'(e_m[1]));
    chk("p4_done", 128'(done1), 128'(e_done[1]));
    chk("p4_err",  128'(err1),  128'(m_err[1] != 0));
    chk("p4_addr", 128'(addr1), 128'(e_addr[1]));
    chk("p4_data", data1,       e_data[1]);
  endtask

  // Apply inputs for one cycle, check combinational outputs, then registered ones.
  task automatic step(input logic rst, input logic st, input logic br, input logic rf);
    rst_r = rst; start_r = st; bitrev_r = br; rf_r = rf;
    rd_r = {32'($urandom), 1'($urandom)};
    #1;
    chk("p2_del", 128'(del0), 128'(!rst && m_act[0] != 0 && rf && !st));
    chk("p4_del", 128'(del1), 128'(!rst && m_act[1] != 0 && rf && !st));
    chk("p2_active", 128'(act0), 128'(m_act[0] != 0 || st));
    chk("p4_active", 128'(act1), 128'(m_act[1] != 0 || st));
    model_step(0, 2);
    model_step(1, 4);
    @(posedge clk);
    @(negedge clk);
    check_regs();
    if (cap_en && !cap_done && nd1) begin
      cap_addr = addr1;
      cap_done = 1'b1;
    end
  endtask

  // Start a frame and feed it; pattern 1 uses read_full 1,0,0 repeating.
  task automatic run_frame(input logic br, input int pattern);
    step(1'b0, 1'b1, br, 1'b0);
    tog = 0;
    for (int c = 0; c < 64 && m_act[0] != 0; c++) begin
      step(1'b0, 1'b0, ~br, (pattern == 0) ? 1'b1 : (tog % 3 == 0));
      tog++;
    end
    chk("frame_end", 128'(m_act[0]), 128'(0));
  endtask

  initial begin
    m_act = '{0, 0};
    cap_en = 1'b0; cap_done = 1'b0; cap_addr = '0;
    rst_r = 1'b1; start_r = 1'b0; bitrev_r = 1'b0; rf_r = 1'b0; rd_r = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

    run_frame(1'b0, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

    cap_en = 1'b1;
    run_frame(1'b1, 0);
    cap_en = 1'b0;
    chk("p4_rev_first_addr", 128'(cap_addr), 128'(12'o6240));

    run_frame(1'b0, 1);

    // second start mid-frame with the other mode
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 20 && m_act[0] != 0; c++) step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("err_sticky", 128'(err0), 128'(1));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_cleared", 128'(err1), 128'(0));

    // reset in the middle of a P=4 group
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_data_zero", data1, 128'(0));
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 0);

    // back-to-back frames
    run_frame(1'b0, 0);
    run_frame(1'b1, 0);
    chk("b2b_no_err", 128'(err0), 128'(0));

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0),
           1'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
